// File: rtl/bus_fifo_rd_port.sv
// Bus-side reader for a normal-mode single-clock FIFO: prefetches one word into a
// holding register and exposes DATA / STATUS / COUNT registers with a one-cycle ack.
module bus_fifo_rd_port #(
    parameter logic [31:0] EMPTY_WORD = 32'h00000000,
    parameter int          CNT_W      = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_empty_i,
    output logic        fifo_re_o,
    input  logic [1:0]  bus_addr_i,
    input  logic        bus_rd_i,
    input  logic        bus_wr_i,
    input  logic [31:0] bus_data_i,
    output logic [31:0] bus_data_o,
    output logic        bus_ack_o
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_REQ,
        ST_LATCH,
        ST_VALID
    } fetchState_t;

    fetchState_t       r_state;
    fetchState_t       w_stateNext;
    logic [31:0]       r_hold;
    logic              r_pending;
    logic              r_underflow;
    logic [CNT_W-1:0]  r_count;
    logic              r_ack;
    logic [31:0]       r_rdData;

    logic              w_strobe;
    logic              w_rdStrobe;
    logic              w_wrStrobe;
    logic              w_dataRd;
    logic              w_holdValid;
    logic              w_fetchSoon;
    logic              w_serve;
    logic              w_setPend;
    logic              w_underflow;
    logic              w_clrUnder;
    logic              w_clrCount;
    logic              w_ackNext;
    logic [31:0]       w_status;
    logic [31:0]       w_rdMux;
    logic              w_unusedWrBits;

    // A pending DATA read blocks every new strobe until it is served.
    assign w_strobe    = (bus_rd_i | bus_wr_i) & ~r_pending;
    assign w_rdStrobe  = w_strobe & bus_rd_i;
    assign w_wrStrobe  = w_strobe & ~bus_rd_i & bus_wr_i;
    assign w_dataRd    = w_rdStrobe & (bus_addr_i == ADDR_DATA);
    assign w_holdValid = (r_state == ST_VALID);
    assign w_fetchSoon = (r_state == ST_REQ) || (r_state == ST_LATCH) ||
                         ((r_state == ST_EMPTY) && !fifo_empty_i);
    assign w_serve     = (r_pending | w_dataRd) & w_holdValid;
    assign w_setPend   = w_dataRd & w_fetchSoon;
    assign w_underflow = w_dataRd & (r_state == ST_EMPTY) & fifo_empty_i;
    assign w_clrUnder  = w_wrStrobe & (bus_addr_i == ADDR_STATUS) & bus_data_i[0];
    assign w_clrCount  = w_wrStrobe & (bus_addr_i == ADDR_STATUS) & bus_data_i[1];
    assign w_ackNext   = w_serve | (w_strobe & ~w_setPend);
    assign w_status    = {28'd0, r_pending, r_underflow, w_holdValid, fifo_empty_i};
    assign w_unusedWrBits = ^bus_data_i[31:2];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        fifo_re_o   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (!fifo_empty_i) begin
                    w_stateNext = ST_REQ;
                end
            end
            ST_REQ: begin
                fifo_re_o   = 1'b1;
                w_stateNext = ST_LATCH;
            end
            ST_LATCH: begin
                w_stateNext = ST_VALID;
            end
            ST_VALID: begin
                if (w_serve) begin
                    w_stateNext = ST_EMPTY;
                end
            end
            default: begin
                w_stateNext = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        w_rdMux = '0;
        if (w_serve) begin
            w_rdMux = r_hold;
        end else if (w_rdStrobe) begin
            case (bus_addr_i)
                ADDR_DATA:   w_rdMux = EMPTY_WORD;
                ADDR_STATUS: w_rdMux = w_status;
                ADDR_COUNT:  w_rdMux = 32'(r_count);
                default:     w_rdMux = '0;
            endcase
        end
    end

    // A count clear beats a simultaneous pop.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_hold      <= '0;
            r_pending   <= 1'b0;
            r_underflow <= 1'b0;
            r_count     <= '0;
            r_ack       <= 1'b0;
            r_rdData    <= '0;
        end else begin
            r_ack <= 1'b0;
            if (r_state == ST_LATCH) begin
                r_hold <= fifo_data_i;
            end
            if (w_serve) begin
                r_pending <= 1'b0;
            end else if (w_setPend) begin
                r_pending <= 1'b1;
            end
            if (w_underflow) begin
                r_underflow <= 1'b1;
            end else if (w_clrUnder) begin
                r_underflow <= 1'b0;
            end
            if (w_clrCount) begin
                r_count <= '0;
            end else if (w_serve) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_ackNext) begin
                r_ack    <= 1'b1;
                r_rdData <= w_rdMux;
            end
        end
    end

    assign bus_ack_o  = r_ack;
    assign bus_data_o = r_rdData;

endmodule
